// File: rtl/cell_allocator_pkg.sv
// Shared constants and types for the cell allocator: object tags, cell sizes,
// error codes and the allocator state encoding.
package cell_allocator_pkg;

  localparam logic [15:0] TYPE_NUMBER = 16'h0001;
  localparam logic [15:0] TYPE_CONS   = 16'h0002;

  localparam logic [1:0] ALLOC_OK      = 2'd0;
  localparam logic [1:0] ALLOC_OOM     = 2'd1;
  localparam logic [1:0] ALLOC_BAD_TAG = 2'd2;

  localparam int unsigned NUMBER_CELL_WORDS = 2;
  localparam int unsigned CONS_CELL_WORDS   = 3;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWrTag,
    StWrW0,
    StWrW1,
    StDone,
    StErr
  } alloc_state_t;

endpackage

// File: rtl/cell_allocator_if.sv
// Allocation request/response bus between the core FSM (master) and the
// cell allocator (slave).
interface cell_allocator_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  alloc_req;
  logic [DATA_WIDTH-1:0] alloc_tag;
  logic [DATA_WIDTH-1:0] alloc_word0;
  logic [DATA_WIDTH-1:0] alloc_word1;
  logic                  alloc_ready;
  logic                  alloc_done;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  alloc_error;
  logic [1:0]            alloc_error_code;

  modport master (
    output alloc_req, alloc_tag, alloc_word0, alloc_word1,
    input  alloc_ready, alloc_done, alloc_addr, alloc_error, alloc_error_code
  );

  modport slave (
    input  alloc_req, alloc_tag, alloc_word0, alloc_word1,
    output alloc_ready, alloc_done, alloc_addr, alloc_error, alloc_error_code
  );
endinterface

// File: rtl/cell_allocator.sv
// Bump-pointer heap allocator: builds NUMBER (2 words) and CONS (3 words) cells
// through a granted memory write port and returns the new object's base address.
module cell_allocator
  import cell_allocator_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = 16'h0100,
  parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT = 16'h01FF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  heap_reset,
  cell_allocator_if.slave       alloc,
  input  logic                  mem_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] free_ptr
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;

  alloc_state_t          state_q;
  logic [DATA_WIDTH-1:0] tag_q, word0_q, word1_q, mem_data_q;
  logic [ADDR_WIDTH-1:0] base_q, size_q, free_q, addr_q, mem_addr_q;
  logic                  cons_q, done_q, error_q;
  logic [1:0]            code_q;

  logic                  is_number, is_cons;
  logic [ADDR_WIDTH-1:0] size_c;
  logic [ADDR_WIDTH:0]   last_c;

  // Last word address is computed one bit wider so a near-top base cannot wrap.
  always_comb begin
    is_number = (tag_q == DATA_WIDTH'(TYPE_NUMBER));
    is_cons   = (tag_q == DATA_WIDTH'(TYPE_CONS));
    size_c    = is_cons ? ADDR_WIDTH'(CONS_CELL_WORDS) : ADDR_WIDTH'(NUMBER_CELL_WORDS);
    last_c    = {1'b0, base_q} + {1'b0, size_c} - AW1'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      word0_q    <= '0;
      word1_q    <= '0;
      base_q     <= '0;
      size_q     <= '0;
      cons_q     <= 1'b0;
      free_q     <= HEAP_BASE;
      addr_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= ALLOC_OK;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (heap_reset) begin
            free_q <= HEAP_BASE;
          end else if (alloc.alloc_req) begin
            tag_q   <= alloc.alloc_tag;
            word0_q <= alloc.alloc_word0;
            word1_q <= alloc.alloc_word1;
            base_q  <= free_q;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          size_q <= size_c;
          cons_q <= is_cons;
          if (!is_number && !is_cons) begin
            state_q <= StErr;
            error_q <= 1'b1;
            code_q  <= ALLOC_BAD_TAG;
          end else if (last_c > {1'b0, HEAP_LIMIT}) begin
            state_q <= StErr;
            error_q <= 1'b1;
            code_q  <= ALLOC_OOM;
          end else begin
            state_q    <= StWrTag;
            mem_addr_q <= base_q;
            mem_data_q <= tag_q;
          end
        end
        StWrTag: begin
          if (mem_grant) begin
            state_q    <= StWrW0;
            mem_addr_q <= base_q + ADDR_WIDTH'(1);
            mem_data_q <= word0_q;
          end
        end
        StWrW0: begin
          if (mem_grant) begin
            if (cons_q) begin
              state_q    <= StWrW1;
              mem_addr_q <= base_q + ADDR_WIDTH'(2);
              mem_data_q <= word1_q;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              addr_q  <= base_q;
              free_q  <= base_q + size_q;
            end
          end
        end
        StWrW1: begin
          if (mem_grant) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            addr_q  <= base_q;
            free_q  <= base_q + size_q;
          end
        end
        StDone: state_q <= StIdle;
        StErr: begin
          if (heap_reset) begin
            state_q <= StIdle;
            error_q <= 1'b0;
            code_q  <= ALLOC_OK;
            free_q  <= HEAP_BASE;
          end
        end
        default: begin
          state_q <= StErr;
          error_q <= 1'b1;
          code_q  <= ALLOC_BAD_TAG;
        end
      endcase
    end
  end

  // Write strobe follows the grant combinationally so a stalled cycle never writes.
  assign mem_write_enable = mem_grant &&
                            ((state_q == StWrTag) || (state_q == StWrW0) || (state_q == StWrW1));
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_data_q;
  assign free_ptr         = free_q;

  assign alloc.alloc_ready      = (state_q == StIdle);
  assign alloc.alloc_done       = done_q;
  assign alloc.alloc_addr       = addr_q;
  assign alloc.alloc_error      = error_q;
  assign alloc.alloc_error_code = code_q;

endmodule

// File: tb/tb_cell_allocator.sv
// Directed self-checking bench for cell_allocator.
module tb_cell_allocator;
  import cell_allocator_pkg::*;

  logic        clk;
  logic        rst;
  logic        heap_reset;
  logic        mem_grant;
  logic [15:0] mem_addr;
  logic        mem_write_enable;
  logic [15:0] mem_write_data;
  logic [15:0] free_ptr;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];

  cell_allocator_if alloc_bus ();

  cell_allocator dut (
    .clk              (clk),
    .rst              (rst),
    .heap_reset       (heap_reset),
    .alloc            (alloc_bus),
    .mem_grant        (mem_grant),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .free_ptr         (free_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && mem_write_enable) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_write_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one edge, then scramble the payload.
  task automatic send_req(input logic [15:0] tag, input logic [15:0] w0, input logic [15:0] w1);
    alloc_bus.alloc_req   = 1'b1;
    alloc_bus.alloc_tag   = tag;
    alloc_bus.alloc_word0 = w0;
    alloc_bus.alloc_word1 = w1;
    @(posedge clk);
    #1;
    alloc_bus.alloc_req   = 1'b0;
    alloc_bus.alloc_tag   = 16'hFFFF;
    alloc_bus.alloc_word0 = 16'hDEAD;
    alloc_bus.alloc_word1 = 16'hDEAD;
  endtask

  task automatic wait_done(input int stall_at, input int stall_len, input logic [15:0] base,
                           input logic [15:0] w0, output int n, output bit seen);
    bit stalled;
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 30) begin
      stalled   = (stall_len > 0) && (n >= stall_at) && (n < stall_at + stall_len);
      mem_grant = !stalled;
      #1;
      if (stalled) begin
        check_eq("stall_we", 32'(mem_write_enable), 32'd0);
        check_eq("stall_addr", 32'(mem_addr), 32'(base + 16'd1));
        check_eq("stall_data", 32'(mem_write_data), 32'(w0));
      end
      if (alloc_bus.alloc_done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    mem_grant = 1'b1;
  endtask

  task automatic alloc_check(input string name, input logic [15:0] tag, input logic [15:0] w0,
                             input logic [15:0] w1, input int stall_at, input int stall_len,
                             input logic [15:0] exp_base, input int exp_n);
    int          n;
    bit          seen;
    int          size;
    logic [15:0] exp_d[3];
    size     = (tag == TYPE_CONS) ? 3 : 2;
    exp_d[0] = tag;
    exp_d[1] = w0;
    exp_d[2] = w1;
    wr_addr.delete();
    wr_data.delete();
    send_req(tag, w0, w1);
    wait_done(stall_at, stall_len, exp_base, w0, n, seen);
    check_eq({name, "_done"}, 32'(seen), 32'd1);
    check_eq({name, "_lat"}, 32'(n), 32'(exp_n));
    check_eq({name, "_addr"}, 32'(alloc_bus.alloc_addr), 32'(exp_base));
    check_eq({name, "_free"}, 32'(free_ptr), 32'(exp_base + 16'(size)));
    check_eq({name, "_nwr"}, 32'(wr_addr.size()), 32'(size));
    for (int i = 0; i < size; i++) begin
      if (i < wr_addr.size()) begin
        check_eq({name, "_wa"}, 32'(wr_addr[i]), 32'(exp_base + 16'(i)));
        check_eq({name, "_wd"}, 32'(wr_data[i]), 32'(exp_d[i]));
      end
    end
    @(posedge clk);
    #1;
    check_eq({name, "_rdy"}, 32'(alloc_bus.alloc_ready), 32'd1);
  endtask

  task automatic err_req(input string name, input logic [15:0] tag, input logic [1:0] code);
    wr_addr.delete();
    wr_data.delete();
    send_req(tag, 16'h0001, 16'h0002);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq({name, "_err"}, 32'(alloc_bus.alloc_error), 32'd1);
    check_eq({name, "_code"}, 32'(alloc_bus.alloc_error_code), 32'(code));
    check_eq({name, "_rdy"}, 32'(alloc_bus.alloc_ready), 32'd0);
    check_eq({name, "_nwr"}, 32'(wr_addr.size()), 32'd0);
    heap_reset = 1'b1;
    @(posedge clk);
    #1;
    heap_reset = 1'b0;
    check_eq({name, "_clr_err"}, 32'(alloc_bus.alloc_error), 32'd0);
    check_eq({name, "_clr_code"}, 32'(alloc_bus.alloc_error_code), 32'd0);
    check_eq({name, "_clr_rdy"}, 32'(alloc_bus.alloc_ready), 32'd1);
    check_eq({name, "_clr_free"}, 32'(free_ptr), 32'h0100);
  endtask

  initial begin
    rst                   = 1'b1;
    heap_reset            = 1'b0;
    mem_grant             = 1'b1;
    alloc_bus.alloc_req   = 1'b0;
    alloc_bus.alloc_tag   = '0;
    alloc_bus.alloc_word0 = '0;
    alloc_bus.alloc_word1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_free", 32'(free_ptr), 32'h0100);
    check_eq("rst_rdy", 32'(alloc_bus.alloc_ready), 32'd1);
    check_eq("rst_done", 32'(alloc_bus.alloc_done), 32'd0);
    check_eq("rst_addr", 32'(alloc_bus.alloc_addr), 32'd0);
    check_eq("rst_err", 32'(alloc_bus.alloc_error), 32'd0);
    check_eq("rst_code", 32'(alloc_bus.alloc_error_code), 32'd0);
    check_eq("rst_we", 32'(mem_write_enable), 32'd0);
    check_eq("rst_maddr", 32'(mem_addr), 32'd0);
    check_eq("rst_mdata", 32'(mem_write_data), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    alloc_check("num", TYPE_NUMBER, 16'h002A, 16'h0000, 0, 0, 16'h0100, 4);
    alloc_check("cons", TYPE_CONS, 16'h0100, 16'h0000, 0, 0, 16'h0102, 5);
    alloc_check("stall", TYPE_CONS, 16'h0100, 16'h0000, 3, 3, 16'h0105, 8);
    for (int k = 0; k < 82; k++) begin
      alloc_check("fill", TYPE_CONS, 16'h0007, 16'h0000, 0, 0, 16'h0108 + 16'(3 * k), 5);
    end
    alloc_check("fit", TYPE_NUMBER, 16'h0055, 16'h0000, 0, 0, 16'h01FE, 4);
    err_req("oom", TYPE_NUMBER, ALLOC_OOM);
    err_req("badtag", 16'hBEEF, ALLOC_BAD_TAG);

    // heap_reset beats a simultaneous request in IDLE.
    alloc_check("num2", TYPE_NUMBER, 16'h1234, 16'h0000, 0, 0, 16'h0100, 4);
    wr_addr.delete();
    wr_data.delete();
    alloc_bus.alloc_req = 1'b1;
    alloc_bus.alloc_tag = TYPE_NUMBER;
    heap_reset          = 1'b1;
    @(posedge clk);
    #1;
    alloc_bus.alloc_req = 1'b0;
    heap_reset          = 1'b0;
    check_eq("hr_rdy", 32'(alloc_bus.alloc_ready), 32'd1);
    check_eq("hr_free", 32'(free_ptr), 32'h0100);
    repeat (5) @(posedge clk);
    #1;
    check_eq("hr_nwr", 32'(wr_addr.size()), 32'd0);

    // Asynchronous reset in the middle of a CONS build.
    send_req(TYPE_CONS, 16'h0100, 16'h0000);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("ar_pre_maddr", 32'(mem_addr), 32'h0102);
    check_eq("ar_pre_we", 32'(mem_write_enable), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_free", 32'(free_ptr), 32'h0100);
    check_eq("ar_we", 32'(mem_write_enable), 32'd0);
    check_eq("ar_maddr", 32'(mem_addr), 32'd0);
    check_eq("ar_mdata", 32'(mem_write_data), 32'd0);
    check_eq("ar_addr", 32'(alloc_bus.alloc_addr), 32'd0);
    check_eq("ar_rdy", 32'(alloc_bus.alloc_ready), 32'd1);
    check_eq("ar_done", 32'(alloc_bus.alloc_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
